mem_port_arbiter: RTL and testbench

- Shares the single-ported unified memory between the IF stage (instruction fetch) and the MEM stage (LWD/SWD) of the pipelined TSC core.
- Serialises requests. Drives a req/ack handshake toward memory with variable latency. Returns data and a one-cycle ready pulse to the winning requester.
- Data accesses have priority. A bounded-starvation counter guarantees fetch progress.
- Stall outputs feed the hazard/pipeline-freeze logic.

---
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for the shared single-ported memory
`timescale 1ns/1ps

module mem_port_arbiter #(
   parameter int WORD_W     = 16,
   parameter int ADDR_W     = 16,
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [WORD_W-1:0] i_data,
   output logic              i_ready,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [WORD_W-1:0] d_wdata,
   output logic [WORD_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              stall_if,
   output logic              stall_mem
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_I_BUSY = 2'd1,
      ST_D_BUSY = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LP_STARVE_MAX = CNT_W'(STARVE_MAX);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_starve_cnt;
   logic [CNT_W-1:0]  w_starve_nxt;
   logic              r_mem_req;
   logic              w_mem_req_nxt;
   logic              r_mem_we;
   logic              w_mem_we_nxt;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [ADDR_W-1:0] w_mem_addr_nxt;
   logic [WORD_W-1:0] r_mem_wdata;
   logic [WORD_W-1:0] w_mem_wdata_nxt;
   logic              w_grant_d;
   logic              w_i_done;
   logic              w_d_done;

   // Arbitration and completion: data wins unless the fetch has waited out STARVE_MAX data grants
   always_comb begin
      w_state_nxt     = r_state;
      w_starve_nxt    = r_starve_cnt;
      w_mem_req_nxt   = r_mem_req;
      w_mem_we_nxt    = r_mem_we;
      w_mem_addr_nxt  = r_mem_addr;
      w_mem_wdata_nxt = r_mem_wdata;
      w_grant_d       = d_req && (!i_req || (r_starve_cnt < LP_STARVE_MAX));
      case (r_state)
         ST_IDLE: begin
            if (w_grant_d) begin
               w_state_nxt     = ST_D_BUSY;
               w_starve_nxt    = i_req ? (r_starve_cnt + 1'b1) : '0;
               w_mem_req_nxt   = 1'b1;
               w_mem_we_nxt    = d_we;
               w_mem_addr_nxt  = d_addr;
               w_mem_wdata_nxt = d_wdata;
            end else if (i_req) begin
               w_state_nxt    = ST_I_BUSY;
               w_starve_nxt   = '0;
               w_mem_req_nxt  = 1'b1;
               w_mem_we_nxt   = 1'b0;
               w_mem_addr_nxt = i_addr;
            end
         end
         ST_I_BUSY, ST_D_BUSY: begin
            // Returning to IDLE (not re-arbitrating here) gives the requester a cycle to drop its req
            if (mem_ack) begin
               w_state_nxt   = ST_IDLE;
               w_mem_req_nxt = 1'b0;
               w_mem_we_nxt  = 1'b0;
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_mem_req_nxt = 1'b0;
            w_mem_we_nxt  = 1'b0;
         end
      endcase
   end

   // State, starvation counter and registered memory-side request
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_starve_cnt <= '0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_nxt;
         r_mem_req    <= w_mem_req_nxt;
         r_mem_we     <= w_mem_we_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_mem_wdata  <= w_mem_wdata_nxt;
      end
   end

   // An ack only counts while a transaction is in flight, so stray acks in IDLE are dropped
   assign w_i_done = (r_state == ST_I_BUSY) && mem_ack;
   assign w_d_done = (r_state == ST_D_BUSY) && mem_ack;

   assign i_ready   = w_i_done;
   assign d_ready   = w_d_done;
   assign i_data    = w_i_done ? mem_rdata : '0;
   assign d_rdata   = (w_d_done && !r_mem_we) ? mem_rdata : '0;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign stall_if  = i_req & ~w_i_done;
   assign stall_mem = d_req & ~w_d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
`timescale 1ns/1ps

module tb_mem_port_arbiter;

   localparam int STARVE_MAX = 4;

   logic        clk;
   logic        reset_n;
   logic        i_req;
   logic [15:0] i_addr;
   logic [15:0] i_data;
   logic        i_ready;
   logic        d_req;
   logic        d_we;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic [15:0] d_rdata;
   logic        d_ready;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;
   logic        stall_if;
   logic        stall_mem;

   int          checks;
   int          errors;
   int          starve_hits;
   int          fixed_lat;
   bit          resp_en;
   bit          spur_en;

   logic [15:0] exp_i[$];
   logic [15:0] exp_d[$];
   logic [15:0] mem_arr[256];
   logic [15:0] ref_arr[256];

   logic        p_mem_req;
   logic        p_i_req;
   logic        p_d_req;
   logic        p_d_we;
   logic        p_done;
   logic [15:0] p_i_addr;
   logic [15:0] p_d_addr;
   logic [15:0] p_d_wdata;
   logic [15:0] g_addr;
   logic [15:0] g_wdata;
   logic        g_we;
   int          streak;

   logic [15:0] rs_addr;
   logic        rs_we;
   logic [15:0] rs_wdata;
   int          rs_lat;

   mem_port_arbiter #(
      .WORD_W(16), .ADDR_W(16), .STARVE_MAX(STARVE_MAX), .CNT_W(4)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_ready(i_ready),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ready(d_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .stall_if(stall_if), .stall_mem(stall_mem)
   );

   initial clk = 1'b0;
   // 100 MHz clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s", name);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_ready(input bit is_d);
      int  n;
      logic seen;
      n    = 0;
      seen = 1'b0;
      while (!seen && n < 300) begin
         @(negedge clk);
         n++;
         seen = is_d ? d_ready : i_ready;
      end
      if (!seen) fail(is_d ? "d_ready_timeout" : "i_ready_timeout");
      @(posedge clk);
      #1;
      if (is_d) d_req = 1'b0;
      else      i_req = 1'b0;
   endtask

   task automatic fetch_one(input logic [15:0] addr);
      i_req  = 1'b1;
      i_addr = addr;
      exp_i.push_back(ref_arr[addr[7:0]]);
      wait_ready(1'b0);
   endtask

   task automatic data_one(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = addr;
      d_wdata = wdata;
      if (we) begin
         ref_arr[addr[7:0]] = wdata;
         exp_d.push_back(16'h0000);
      end else begin
         exp_d.push_back(ref_arr[addr[7:0]]);
      end
      wait_ready(1'b1);
   endtask

   task automatic fetch_seq(input int n, input int max_idle);
      for (int k = 0; k < n; k++) begin
         fetch_one({8'($urandom_range(0, 255)), 8'($urandom_range(1, 127))});
         idle_cycles($urandom_range(0, max_idle));
      end
   endtask

   task automatic data_seq(input int n, input int max_idle);
      for (int k = 0; k < n; k++) begin
         data_one(1'($urandom_range(0, 1)),
                  {8'($urandom_range(0, 255)), 8'($urandom_range(128, 255))},
                  16'($urandom));
         idle_cycles($urandom_range(0, max_idle));
      end
   endtask

   // Memory model: variable-latency ack after each new request, optional stray acks while idle
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      forever begin
         @(negedge clk);
         if (resp_en && reset_n && mem_req) begin
            rs_addr  = mem_addr;
            rs_we    = mem_we;
            rs_wdata = mem_wdata;
            rs_lat   = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
            repeat (rs_lat) @(posedge clk);
            #1;
            if (rs_we) begin
               mem_arr[rs_addr[7:0]] = rs_wdata;
               mem_rdata = 16'($urandom);
            end else begin
               mem_rdata = mem_arr[rs_addr[7:0]];
            end
            mem_ack = 1'b1;
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = 16'($urandom);
         end else if (resp_en && spur_en && !mem_req && !i_req && !d_req &&
                      $urandom_range(0, 7) == 0) begin
            @(posedge clk);
            #1;
            mem_rdata = 16'($urandom);
            mem_ack   = 1'b1;
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard on ready pulses and checks every grant against the arbitration rule
   initial begin
      p_mem_req = 1'b0;
      p_i_req   = 1'b0;
      p_d_req   = 1'b0;
      p_d_we    = 1'b0;
      p_done    = 1'b0;
      streak    = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            streak = 0;
            p_done = 1'b0;
         end else begin
            if (p_done) chk("idle_after_completion", 32'(mem_req), 32'd0);
            if (i_ready) begin
               if (exp_i.size() == 0) fail("i_ready_unexpected");
               else chk("i_data", 32'(i_data), 32'(exp_i.pop_front()));
            end else begin
               chk("i_data_idle", 32'(i_data), 32'd0);
            end
            if (d_ready) begin
               if (exp_d.size() == 0) fail("d_ready_unexpected");
               else chk("d_rdata", 32'(d_rdata), 32'(exp_d.pop_front()));
            end else begin
               chk("d_rdata_idle", 32'(d_rdata), 32'd0);
            end
            chk("stall_if", 32'(stall_if), 32'(i_req & ~i_ready));
            chk("stall_mem", 32'(stall_mem), 32'(d_req & ~d_ready));
            if (!mem_req) chk("mem_we_idle", 32'(mem_we), 32'd0);
            if (mem_req && !p_mem_req) begin
               if (p_d_req && !p_i_req) begin
                  streak = 0;
                  g_we = p_d_we; g_addr = p_d_addr; g_wdata = p_d_wdata;
               end else if (p_i_req && !p_d_req) begin
                  streak = 0;
                  g_we = 1'b0; g_addr = p_i_addr;
               end else if (p_i_req && p_d_req && streak < STARVE_MAX) begin
                  streak++;
                  g_we = p_d_we; g_addr = p_d_addr; g_wdata = p_d_wdata;
               end else if (p_i_req && p_d_req) begin
                  streak = 0;
                  starve_hits++;
                  g_we = 1'b0; g_addr = p_i_addr;
               end else begin
                  fail("grant_without_request");
               end
               chk("grant_addr", 32'(mem_addr), 32'(g_addr));
               chk("grant_we", 32'(mem_we), 32'(g_we));
               if (g_we) chk("grant_wdata", 32'(mem_wdata), 32'(g_wdata));
            end else if (mem_req) begin
               chk("hold_addr", 32'(mem_addr), 32'(g_addr));
               chk("hold_we", 32'(mem_we), 32'(g_we));
               if (g_we) chk("hold_wdata", 32'(mem_wdata), 32'(g_wdata));
            end
            p_done = i_ready | d_ready;
         end
         p_mem_req = mem_req;
         p_i_req   = i_req;
         p_i_addr  = i_addr;
         p_d_req   = d_req;
         p_d_we    = d_we;
         p_d_addr  = d_addr;
         p_d_wdata = d_wdata;
      end
   end

   // Watchdog so the run always ends
   initial begin
      #400000;
      $display("FAIL watchdog_expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // Directed phases followed by randomized traffic
   initial begin
      int n;
      checks      = 0;
      errors      = 0;
      starve_hits = 0;
      for (int k = 0; k < 256; k++) begin
         mem_arr[k] = 16'($urandom);
         ref_arr[k] = mem_arr[k];
      end
      mem_arr[8'h10] = 16'h6A05;
      ref_arr[8'h10] = 16'h6A05;
      reset_n   = 1'b0;
      i_req     = 1'b0;
      i_addr    = 16'h0000;
      d_req     = 1'b0;
      d_we      = 1'b0;
      d_addr    = 16'h0000;
      d_wdata   = 16'h0000;
      resp_en   = 1'b1;
      spur_en   = 1'b0;
      fixed_lat = 2;

      repeat (2) @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_i_ready", 32'(i_ready), 32'd0);
      chk("rst_d_ready", 32'(d_ready), 32'd0);
      chk("rst_i_data", 32'(i_data), 32'd0);
      chk("rst_d_rdata", 32'(d_rdata), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      idle_cycles(1);

      // Single fetch
      i_req  = 1'b1;
      i_addr = 16'h0010;
      exp_i.push_back(16'h6A05);
      @(negedge clk);
      chk("fetch_pre_grant_mem_req", 32'(mem_req), 32'd0);
      chk("fetch_pre_grant_stall_if", 32'(stall_if), 32'd1);
      @(negedge clk);
      chk("fetch_grant_mem_req", 32'(mem_req), 32'd1);
      chk("fetch_grant_mem_addr", 32'(mem_addr), 32'h0010);
      chk("fetch_grant_mem_we", 32'(mem_we), 32'd0);
      wait_ready(1'b0);

      // Simultaneous requests: data first, then fetch
      fork
         fetch_one(16'h0020);
         data_one(1'b0, 16'h0100, 16'h0000);
      join
      idle_cycles(2);

      // Starvation guard with latency 1 and both requesters always pending
      fixed_lat   = 1;
      starve_hits = 0;
      fork
         fetch_seq(3, 0);
         data_seq(16, 0);
      join
      chk("starve_fetch_grants", 32'(starve_hits), 32'd3);
      idle_cycles(2);

      // Store
      fixed_lat = 2;
      data_one(1'b1, 16'h0200, 16'hBEEF);
      idle_cycles(2);

      // Randomized traffic with random latency and stray acks
      fixed_lat = 0;
      spur_en   = 1'b1;
      fork
         fetch_seq(30, 3);
         data_seq(40, 3);
      join
      spur_en = 1'b0;
      idle_cycles(4);
      chk("scoreboard_drained", 32'(exp_i.size() + exp_d.size()), 32'd0);

      // Spurious ack while idle
      resp_en = 1'b0;
      idle_cycles(1);
      mem_rdata = 16'hFFFF;
      mem_ack   = 1'b1;
      @(negedge clk);
      chk("spur_i_ready", 32'(i_ready), 32'd0);
      chk("spur_d_ready", 32'(d_ready), 32'd0);
      chk("spur_i_data", 32'(i_data), 32'd0);
      chk("spur_mem_req", 32'(mem_req), 32'd0);
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      @(negedge clk);
      chk("spur_after_mem_req", 32'(mem_req), 32'd0);
      @(posedge clk);
      #1;

      // Reset in the middle of a data transaction
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 16'h0180;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_req && n < 10);
      if (!mem_req) fail("midrst_grant_timeout");
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      d_req   = 1'b0;
      #1;
      chk("midrst_mem_req", 32'(mem_req), 32'd0);
      chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
      chk("midrst_mem_we", 32'(mem_we), 32'd0);
      chk("midrst_d_ready", 32'(d_ready), 32'd0);
      chk("midrst_stall_mem", 32'(stall_mem), 32'd0);
      idle_cycles(2);
      reset_n = 1'b1;
      idle_cycles(2);
      mem_rdata = 16'h1234;
      mem_ack   = 1'b1;
      @(negedge clk);
      chk("midrst_late_ack_d_ready", 32'(d_ready), 32'd0);
      chk("midrst_late_ack_d_rdata", 32'(d_rdata), 32'd0);
      chk("midrst_late_ack_mem_req", 32'(mem_req), 32'd0);
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      @(negedge clk);
      chk("midrst_idle_mem_req", 32'(mem_req), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
